// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

   // Width of the single adder slice the operands are stepped through.
   localparam int NIBBLE_W = 4;

   // Sequencer states: accept, step nibbles, hold result for the consumer.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between the ALU issue logic and the serial adder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the request and the result side.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry_out;
   logic             overflow;
   logic             zero;

   // Requester/consumer side.
   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow, zero
   );

   // Adder side.
   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, result, carry_out, overflow, zero
   );
endinterface

// File: rtl/nibble_serial_adder_adder4.sv
// 4-bit ripple adder slice with carry in and carry out.
// Latency: combinational.
// Backpressure: none.
module adder4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       ci_i,
   output logic [3:0] sum_o,
   output logic       co_o
);
   assign {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, ci_i};
endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit add/subtract stepped one nibble per cycle through a single adder4.
// Latency: result valid WIDTH/4 edges after the accept edge.
// Backpressure: result held until out_ready; no new request taken until then.
module nibble_serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   nibble_serial_adder_if.slave bus
);

   localparam int N     = WIDTH / NIBBLE_W;
   localparam int CNT_W = $clog2(N) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

   generate
      if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
         $error("nibble_serial_adder: WIDTH must be a non-zero multiple of 4");
      end
   endgenerate

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     opa_q, opa_d;
   logic [WIDTH-1:0]     opb_q, opb_d;
   logic [WIDTH-1:0]     res_q, res_d;
   logic                 carry_q, carry_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;

   logic [NIBBLE_W-1:0]       sum4;
   logic                      co4;
   logic [WIDTH+NIBBLE_W-1:0] res_shift;

   // Only this slice adds; inter-nibble carry travels through carry_q.
   adder4 u_adder4 (
      .a_i   (opa_q[NIBBLE_W-1:0]),
      .b_i   (opb_q[NIBBLE_W-1:0]),
      .ci_i  (carry_q),
      .sum_o (sum4),
      .co_o  (co4)
   );

   // New nibble enters at the top so the LSB nibble ends up at the bottom.
   assign res_shift = {sum4, res_q};

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         res_q    <= '0;
         carry_q  <= 1'b0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opa_q    <= opa_d;
         opb_q    <= opb_d;
         res_q    <= res_d;
         carry_q  <= carry_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
      end
   end

   // Next-state: latch operands on accept, step one nibble per RUN cycle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      carry_d  = carry_q;
      sign_a_d = sign_a_q;
      sign_b_d = sign_b_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               opa_d    = bus.a;
               opb_d    = bus.sub ? ~bus.b : bus.b;
               carry_d  = bus.sub;   // +1 completes the two's complement of B
               sign_a_d = bus.a[WIDTH-1];
               sign_b_d = opb_d[WIDTH-1];
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            opa_d   = opa_q >> NIBBLE_W;
            opb_d   = opb_q >> NIBBLE_W;
            res_d   = res_shift[WIDTH+NIBBLE_W-1:NIBBLE_W];
            carry_d = co4;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = res_q;
   assign bus.carry_out = carry_q;
   assign bus.overflow  = (sign_a_q == sign_b_q) && (res_q[WIDTH-1] != sign_a_q);
   assign bus.zero      = ~|res_q;

`ifndef SYNTHESIS
   logic [WIDTH-1:0] chk_a_q;
   logic [WIDTH-1:0] chk_b_q;
   logic             chk_sub_q;

   // Full-width copies of the accepted operands, used only to cross-check the result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chk_a_q   <= '0;
         chk_b_q   <= '0;
         chk_sub_q <= 1'b0;
      end else if (state_q == IDLE && bus.in_valid) begin
         chk_a_q   <= bus.a;
         chk_b_q   <= opb_d;
         chk_sub_q <= bus.sub;
      end
   end

   a_done_sum: assert property (@(posedge clk) disable iff (!reset_n)
      (state_q == DONE) |-> ({carry_q, res_q} ==
         ({1'b0, chk_a_q} + {1'b0, chk_b_q} + {{WIDTH{1'b0}}, chk_sub_q})));
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=32 and WIDTH=4 builds).
// Latency: checks N+1 edges from accept to out_valid.
// Backpressure: holds out_ready low to check the result is frozen.
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   logic rst_n;
   int   tests_run    = 0;
   int   tests_failed = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.WIDTH(32)) bus32 ();
   nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

   nibble_serial_adder #(.WIDTH(32)) dut32 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus32.slave)
   );

   nibble_serial_adder #(.WIDTH(4)) dut4 (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus4.slave)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and return #1 after its accept edge.
   task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
      int n = 0;
      while (!bus32.in_ready && n < 50) begin
         tick();
         n++;
      end
      bus32.a        = a;
      bus32.b        = b;
      bus32.sub      = s;
      bus32.in_valid = 1'b1;
      tick();
      bus32.in_valid = 1'b0;
   endtask

   // Count edges (accept edge included) until out_valid, bounded.
   task automatic wait_done32(input int lat0, output int lat);
      lat = lat0;
      while (!bus32.out_valid && lat < 60) begin
         tick();
         lat++;
      end
   endtask

   task automatic consume32();
      bus32.out_ready = 1'b1;
      tick();
      bus32.out_ready = 1'b0;
   endtask

   task automatic run_op32(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] exp_res,
                           input logic exp_c, input logic exp_o);
      int lat;
      start32(a, b, s);
      wait_done32(1, lat);
      check({tag, ".latency"}, 64'(lat), 64'd9);
      check({tag, ".result"}, 64'(bus32.result), 64'(exp_res));
      check({tag, ".carry"}, 64'(bus32.carry_out), 64'(exp_c));
      check({tag, ".overflow"}, 64'(bus32.overflow), 64'(exp_o));
      check({tag, ".zero"}, 64'(bus32.zero), 64'(exp_res == 32'h0));
      consume32();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  lat;
      logic seen;

      rst_n           = 1'b0;
      bus32.in_valid  = 1'b0;
      bus32.a         = '0;
      bus32.b         = '0;
      bus32.sub       = 1'b0;
      bus32.out_ready = 1'b0;
      bus4.in_valid   = 1'b0;
      bus4.a          = '0;
      bus4.b          = '0;
      bus4.sub        = 1'b0;
      bus4.out_ready  = 1'b0;

      tick();
      tick();
      check("reset.in_ready", 64'(bus32.in_ready), 64'd1);
      check("reset.out_valid", 64'(bus32.out_valid), 64'd0);
      check("reset.result", 64'(bus32.result), 64'd0);
      check("reset.carry", 64'(bus32.carry_out), 64'd0);
      check("reset.overflow", 64'(bus32.overflow), 64'd0);
      check("reset.zero", 64'(bus32.zero), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // Directed arithmetic vectors.
      run_op32("add1p1", 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
      run_op32("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
      run_op32("sub5m7", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
      run_op32("subovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
      run_op32("mixed", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

      // Backpressure: result and flags frozen, no new request accepted.
      start32(32'h7000_0000, 32'h1000_0000, 1'b0);
      wait_done32(1, lat);
      check("bp.latency", 64'(lat), 64'd9);
      bus32.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("bp.result[%0d]", i), 64'(bus32.result), 64'h8000_0000);
         check($sformatf("bp.in_ready[%0d]", i), 64'(bus32.in_ready), 64'd0);
         check($sformatf("bp.out_valid[%0d]", i), 64'(bus32.out_valid), 64'd1);
      end
      bus32.in_valid = 1'b0;
      check("bp.overflow", 64'(bus32.overflow), 64'd1);
      consume32();

      // Operand changes and in_valid pulses during RUN are ignored.
      start32(32'h0000_0010, 32'h0000_0020, 1'b0);
      lat = 1;
      for (int i = 0; i < 4; i++) begin
         bus32.a        = 32'hDEAD_0000 + 32'(i);
         bus32.b        = 32'hBEEF_0000 + 32'(i);
         bus32.sub      = i[0];
         bus32.in_valid = ~i[0];
         check($sformatf("run.in_ready[%0d]", i), 64'(bus32.in_ready), 64'd0);
         tick();
         lat++;
      end
      bus32.in_valid = 1'b0;
      wait_done32(lat, lat);
      check("toggle.latency", 64'(lat), 64'd9);
      check("toggle.result", 64'(bus32.result), 64'h0000_0030);
      check("toggle.carry", 64'(bus32.carry_out), 64'd0);
      consume32();
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | bus32.out_valid;
      end
      check("toggle.no_ghost_op", 64'(seen), 64'd0);

      // Reset in the middle of RUN discards the operation.
      start32(32'h0F0F_0F0F, 32'h0101_0101, 1'b0);
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst.in_ready", 64'(bus32.in_ready), 64'd1);
      check("midrst.out_valid", 64'(bus32.out_valid), 64'd0);
      check("midrst.result", 64'(bus32.result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         seen = seen | bus32.out_valid;
      end
      check("midrst.no_pulse", 64'(seen), 64'd0);
      run_op32("postrst", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);

      // WIDTH=4 build: two-edge latency.
      bus4.a        = 4'hF;
      bus4.b        = 4'h1;
      bus4.sub      = 1'b0;
      bus4.in_valid = 1'b1;
      tick();
      bus4.in_valid = 1'b0;
      lat = 1;
      while (!bus4.out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check("w4.latency", 64'(lat), 64'd2);
      check("w4.result", 64'(bus4.result), 64'h0);
      check("w4.carry", 64'(bus4.carry_out), 64'd1);
      check("w4.zero", 64'(bus4.zero), 64'd1);
      check("w4.overflow", 64'(bus4.overflow), 64'd0);
      bus4.out_ready = 1'b1;
      tick();
      bus4.out_ready = 1'b0;
      check("w4.in_ready", 64'(bus4.in_ready), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
